// File: rtl/jpeg_rle_pkg.sv
// Shared types and helpers for the JPEG run-length stage.
package jpeg_rle_pkg;

  // Intake framing states: waiting for a DC sample, or walking the AC samples.
  typedef enum logic {
    ST_DC = 1'b0,
    ST_AC = 1'b1
  } rle_state_e;

  // Symbol flags. They are combined with the width-dependent rlen/size/amp
  // fields into the full symbol struct inside each parameterised module.
  typedef struct packed {
    logic dcterm;
    logic eob;
    logic zrl;
  } sym_flags_t;

  // Category: MSB index + 1 of the (dw-1)-bit magnitude, 0 for zero.
  // The most negative input has a zero magnitude field and yields 0.
  function automatic int unsigned rle_size(input logic signed [31:0] x, input int dw);
    logic [31:0] mag;
    int unsigned s;
    mag = x[31] ? 32'(-x) : 32'(x);
    s   = 0;
    for (int unsigned i = 0; i < 31; i++) begin
      if ((int'(i) < dw - 1) && mag[i]) s = i + 1;
    end
    return s;
  endfunction

  // Amplitude: the value itself when non-negative, value-1 when negative.
  function automatic logic signed [31:0] rle_amp(input logic signed [31:0] x);
    return x[31] ? (x - 32'sd1) : x;
  endfunction

  // FIFO depth must be a power of two large enough to hold one block's
  // worth of pending ZRLs plus the committing symbol and one in flight.
  function automatic bit depth_ok(input int depth, input int blk_log2, input int run_w);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (depth >= ((1 << blk_log2) >> run_w) + 2);
  endfunction

endpackage

// File: rtl/jpeg_rle_pgen_if.sv
// Coefficient input and symbol output bundle of the run-length stage.
interface jpeg_rle_pgen_if #(
  parameter int DW    = 12,
  parameter int RUN_W = 4
);
  localparam int SW = $clog2(DW);

  logic             ena;
  logic             go;
  logic [DW-1:0]    din;
  logic [RUN_W-1:0] rlen;
  logic [SW-1:0]    size;
  logic [DW-1:0]    amp;
  logic             den;
  logic             dcterm;
  logic             eob;
  logic             zrl;

  modport master (
    output ena, go, din,
    input  rlen, size, amp, den, dcterm, eob, zrl
  );

  modport slave (
    input  ena, go, din,
    output rlen, size, amp, den, dcterm, eob, zrl
  );
endinterface

// File: rtl/jpeg_rle_cfifo.sv
// Symbol FIFO with a commit pointer: the reader only sees entries below the
// commit pointer; rewind drops everything written since the last commit.
module jpeg_rle_cfifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rewind_i,
  input  logic         commit_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         avail_o,
  output logic         full_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_P = (PW + 1)'(DEPTH);

  logic [PW:0]  wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d;
  logic [PW:0]  base;
  logic         wr_ok;
  logic [W-1:0] mem_q [DEPTH];

  // Rewind applies before this cycle's write, so the new entry lands at the
  // commit pointer; commit covers the entry written in the same cycle.
  always_comb begin
    base    = rewind_i ? cptr_q : wptr_q;
    full_o  = ((base - rptr_q) == DEPTH_P);
    wr_ok   = en_i && wr_en_i && !full_o;
    wptr_d  = wr_ok ? (base + 1'b1) : base;
    cptr_d  = commit_i ? wptr_d : cptr_q;
    rptr_d  = (rd_en_i && avail_o) ? (rptr_q + 1'b1) : rptr_q;
  end

  assign avail_o   = (cptr_q != rptr_q);
  assign rd_data_o = mem_q[rptr_q[PW-1:0]];

  // Pointer registers, advanced only on enabled cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      cptr_q <= '0;
      rptr_q <= '0;
    end else if (en_i) begin
      wptr_q <= wptr_d;
      cptr_q <= cptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage array; contents are only meaningful below the write pointer.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[base[PW-1:0]] <= wr_data_i;
  end
endmodule

// File: rtl/jpeg_rle_pgen.sv
// Run-length stage: quantised zig-zag coefficients in, (run, size, amp)
// symbols out, with ZRLs held back until a nonzero coefficient needs them.
module jpeg_rle_pgen
  import jpeg_rle_pkg::*;
#(
  parameter int DW       = 12,
  parameter int BLK_LOG2 = 6,
  parameter int RUN_W    = 4,
  parameter int DEPTH    = 8
) (
  input  logic            clk,
  input  logic            rst,
  jpeg_rle_pgen_if.slave  bus,
  output logic            ovf
);
  localparam int SW = $clog2(DW);

  typedef struct packed {
    logic [RUN_W-1:0] rlen;
    logic [SW-1:0]    size;
    logic [DW-1:0]    amp;
    sym_flags_t       flags;
  } sym_t;

  if (!depth_ok(DEPTH, BLK_LOG2, RUN_W)) begin : g_bad_depth
    $error("jpeg_rle_pgen: DEPTH too small or not a power of two");
  end

  rle_state_e          state_q, state_d;
  logic [BLK_LOG2-1:0] cnt_q, cnt_d;
  logic [RUN_W-1:0]    zc_q, zc_d;
  logic                wr_en, wr_commit, wr_rewind;
  sym_t                wr_sym, rd_sym;
  logic                fifo_avail, fifo_full;
  logic                din_zero, last_ac;
  logic [SW-1:0]       sym_size;
  logic [DW-1:0]       sym_amp;

  logic [RUN_W-1:0]    rlen_q;
  logic [SW-1:0]       size_q;
  logic [DW-1:0]       amp_q;
  logic                den_q, dcterm_q, eob_q, zrl_q, ovf_q;

  // Intake decode: one FIFO write per enabled cycle plus next framing state.
  // go always rewinds: in DC nothing is pending, in AC it aborts the block.
  always_comb begin
    din_zero  = (bus.din == '0);
    last_ac   = (cnt_q == '1);
    sym_size  = SW'(rle_size(32'(signed'(bus.din)), DW));
    sym_amp   = DW'(rle_amp(32'(signed'(bus.din))));
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    zc_d      = zc_q;
    wr_en     = 1'b0;
    wr_commit = 1'b0;
    wr_rewind = 1'b0;
    wr_sym    = '0;
    wr_sym.size = sym_size;
    wr_sym.amp  = sym_amp;
    if (bus.go) begin
      wr_rewind           = 1'b1;
      wr_en               = 1'b1;
      wr_commit           = 1'b1;
      wr_sym.flags.dcterm = 1'b1;
      zc_d                = '0;
      cnt_d               = BLK_LOG2'(1);
      state_d             = ST_AC;
    end else if (state_q == ST_AC) begin
      if (!din_zero) begin
        wr_en       = 1'b1;
        wr_commit   = 1'b1;
        wr_sym.rlen = zc_q;
        zc_d        = '0;
        if (last_ac) state_d = ST_DC;
      end else if (last_ac) begin
        wr_rewind        = 1'b1;
        wr_en            = 1'b1;
        wr_commit        = 1'b1;
        wr_sym.flags.eob = 1'b1;
        zc_d             = '0;
        state_d          = ST_DC;
      end else if (zc_q == '1) begin
        wr_en            = 1'b1;
        wr_sym.rlen      = '1;
        wr_sym.flags.zrl = 1'b1;
        zc_d             = '0;
      end else begin
        zc_d = zc_q + 1'b1;
      end
    end
  end

  // Framing state, sample counter and zero-run counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_DC;
      cnt_q   <= '0;
      zc_q    <= '0;
    end else if (bus.ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      zc_q    <= zc_d;
    end
  end

  jpeg_rle_cfifo #(
    .W     ($bits(sym_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .en_i      (bus.ena),
    .wr_en_i   (wr_en),
    .wr_data_i (wr_sym),
    .rewind_i  (wr_rewind),
    .commit_i  (wr_commit),
    .rd_en_i   (fifo_avail),
    .rd_data_o (rd_sym),
    .avail_o   (fifo_avail),
    .full_o    (fifo_full)
  );

  // Output stage: pop one committed symbol per enabled cycle; sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rlen_q   <= '0;
      size_q   <= '0;
      amp_q    <= '0;
      den_q    <= 1'b0;
      dcterm_q <= 1'b0;
      eob_q    <= 1'b0;
      zrl_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (bus.ena) begin
      if (fifo_avail) begin
        rlen_q   <= rd_sym.rlen;
        size_q   <= rd_sym.size;
        amp_q    <= rd_sym.amp;
        den_q    <= 1'b1;
        dcterm_q <= rd_sym.flags.dcterm;
        eob_q    <= rd_sym.flags.eob;
        zrl_q    <= rd_sym.flags.zrl;
      end else begin
        den_q    <= 1'b0;
        dcterm_q <= 1'b0;
        eob_q    <= 1'b0;
        zrl_q    <= 1'b0;
      end
      if (wr_en && fifo_full) ovf_q <= 1'b1;
    end
  end

  assign bus.rlen   = rlen_q;
  assign bus.size   = size_q;
  assign bus.amp    = amp_q;
  assign bus.den    = den_q;
  assign bus.dcterm = dcterm_q;
  assign bus.eob    = eob_q;
  assign bus.zrl    = zrl_q;
  assign ovf        = ovf_q;
endmodule

// File: tb/tb_jpeg_rle_pgen.sv
// Self-checking bench for jpeg_rle_pgen: block-level JPEG run-length model.
module tb_jpeg_rle_pgen;
  localparam int DW = 12, BLK_LOG2 = 6, RUN_W = 4, DEPTH = 8;

  typedef logic signed [11:0] blk_t [64];
  typedef struct packed {
    logic [3:0]  rlen;
    logic [3:0]  size;
    logic [11:0] amp;
    logic        dcterm;
    logic        eob;
    logic        zrl;
  } tsym_t;

  localparam tsym_t ZRL_SYM = '{rlen: 4'hF, size: 4'h0, amp: 12'h000, dcterm: 1'b0, eob: 1'b0, zrl: 1'b1};
  localparam tsym_t EOB_SYM = '{rlen: 4'h0, size: 4'h0, amp: 12'h000, dcterm: 1'b0, eob: 1'b1, zrl: 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ovf;
  int   vectors = 0;
  int   miscompares = 0;
  tsym_t obs_q[$];
  tsym_t exp_q[$];

  jpeg_rle_pgen_if #(.DW(DW), .RUN_W(RUN_W)) bus ();

  jpeg_rle_pgen #(.DW(DW), .BLK_LOG2(BLK_LOG2), .RUN_W(RUN_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .ovf (ovf)
  );

  always #5 clk = ~clk;

  // A symbol is consumed at the next edge where ena is high.
  always @(negedge clk) begin
    if (rst && bus.ena && bus.den)
      obs_q.push_back({bus.rlen, bus.size, bus.amp, bus.dcterm, bus.eob, bus.zrl});
  end

  function automatic string s2s(input tsym_t s);
    return $sformatf("{rlen=%0d size=%0d amp=%h dc=%b eob=%b zrl=%b}",
                     s.rlen, s.size, s.amp, s.dcterm, s.eob, s.zrl);
  endfunction

  // Reference symbol from a coefficient value: size = bits needed for |v|.
  function automatic tsym_t mk_sym(input int unsigned run, input logic signed [11:0] v, input bit dc);
    tsym_t s;
    int    mag;
    mag      = (v < 0) ? -int'(v) : int'(v);
    s        = '0;
    s.rlen   = 4'(run);
    s.size   = 4'($clog2(mag + 1));
    s.amp    = (v < 0) ? 12'(int'(v) - 1) : 12'(v);
    s.dcterm = dc;
    return s;
  endfunction

  // JPEG rule on the first n samples of a block: each nonzero AC carries
  // run/16 ZRLs and run%16; a complete block ending in zero adds EOB.
  function automatic void model_block(input blk_t b, input int unsigned n);
    int unsigned run;
    run = 0;
    exp_q.push_back(mk_sym(0, b[0], 1'b1));
    for (int unsigned i = 1; i < n; i++) begin
      if (b[i] == 0) run++;
      else begin
        for (int unsigned z = 0; z < run / 16; z++) exp_q.push_back(ZRL_SYM);
        exp_q.push_back(mk_sym(run % 16, b[i], 1'b0));
        run = 0;
      end
    end
    if (n == 64 && b[63] == 0) exp_q.push_back(EOB_SYM);
  endfunction

  function automatic logic signed [11:0] rand_nz();
    int unsigned sz;
    int          v;
    sz = $urandom_range(1, 11);
    v  = int'($urandom_range((1 << (sz - 1)), (1 << sz) - 1));
    if ($urandom_range(1) == 1) v = -v;
    return 12'(v);
  endfunction

  function automatic void gen_block(output blk_t b, input int unsigned zpct);
    for (int unsigned i = 0; i < 64; i++)
      b[i] = ($urandom_range(99) < zpct) ? 12'sd0 : rand_nz();
  endfunction

  task automatic drive(input logic g, input logic [11:0] d);
    bus.go = g; bus.din = d; bus.ena = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic stall(input int unsigned n);
    bus.ena = 1'b0;
    repeat (n) @(posedge clk);
    #1 bus.ena = 1'b1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 12'h000);
  endtask

  // Non-go samples while in DC must be ignored.
  task automatic idle_noise(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 12'($urandom));
  endtask

  task automatic run_block(input blk_t b, input int unsigned n, input int unsigned stall_pct);
    for (int unsigned i = 0; i < n; i++) begin
      if ($urandom_range(99) < stall_pct) stall($urandom_range(1, 3));
      drive(i == 0, b[i]);
    end
    bus.go = 1'b0;
    model_block(b, n);
  endtask

  task automatic test_reset();
    bus.ena = 1'b0; bus.go = 1'b0; bus.din = '0;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({bus.rlen, bus.size, bus.amp, bus.den, bus.dcterm, bus.eob, bus.zrl, ovf} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %s den=%b ovf=%b, want all 0",
               s2s({bus.rlen, bus.size, bus.amp, bus.dcterm, bus.eob, bus.zrl}), bus.den, ovf);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(4);
    vectors++;
    if (bus.den !== 1'b0 || obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_idle: den=%b symbols=%0d, want den=0 symbols=0", bus.den, obs_q.size());
    end
  endtask

  task automatic test_latency();
    drive(1'b1, 12'h005);
    vectors++;
    if (bus.den !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_n1: den=%b want 0", bus.den);
    end
    drive(1'b0, 12'h000);
    vectors++;
    if (bus.den !== 1'b1 || bus.amp !== 12'h005 || bus.dcterm !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_n2: den=%b amp=%h dc=%b want den=1 amp=005 dc=1", bus.den, bus.amp, bus.dcterm);
    end
    for (int unsigned i = 2; i < 64; i++) drive(1'b0, 12'h000);
    idle(4);
    vectors++;
    if (obs_q.size() != 2 || obs_q[obs_q.size() - 1] !== EOB_SYM) begin
      miscompares++;
      $display("FAIL latency_block: got %0d symbols, want DC then EOB", obs_q.size());
    end
    obs_q.delete();
  endtask

  // Directed blocks from the test plan, each checked against the model plus
  // one constant spot check of the symbol called out for that block.
  task automatic test_directed();
    blk_t        b;
    tsym_t       spot;
    int unsigned si;
    for (int unsigned d = 0; d < 5; d++) begin
      for (int unsigned i = 0; i < 64; i++) b[i] = 12'sd0;
      case (d)
        0: begin b[0] = 12'sd5;                    si = 0; spot = '{0, 3, 12'h005, 1'b1, 1'b0, 1'b0}; end
        1: begin b[0] = 12'sd0;  b[2] = -12'sd3;   si = 1; spot = '{1, 2, 12'hFFC, 1'b0, 1'b0, 1'b0}; end
        2: begin b[0] = 12'sd77; b[21] = 12'sd5;   si = 2; spot = '{4, 3, 12'h005, 1'b0, 1'b0, 1'b0}; end
        3: begin b[0] = -12'sd2; b[63] = 12'sd1;   si = 4; spot = '{14, 1, 12'h001, 1'b0, 1'b0, 1'b0}; end
        default: begin b[0] = -12'sd7;             si = 1; spot = EOB_SYM; end
      endcase
      run_block(b, 64, 0);
      idle(8);
      vectors++;
      if (obs_q.size() != exp_q.size()) begin
        miscompares++;
        $display("FAIL directed%0d_count: got %0d symbols want %0d", d, obs_q.size(), exp_q.size());
      end
      for (int unsigned i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        vectors++;
        if (obs_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL directed%0d_sym%0d: got %s want %s", d, i, s2s(obs_q[i]), s2s(exp_q[i]));
        end
      end
      vectors++;
      if (obs_q.size() <= si || obs_q[si] !== spot) begin
        miscompares++;
        $display("FAIL directed%0d_spot: got %s want %s", d,
                 (obs_q.size() > si) ? s2s(obs_q[si]) : "none", s2s(spot));
      end
      obs_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_abort();
    blk_t a, b;
    for (int unsigned i = 0; i < 64; i++) a[i] = 12'sd0;
    a[0] = 12'sd9;
    gen_block(b, 80);
    run_block(a, 21, 0);
    run_block(b, 64, 0);
    idle(8);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL abort_count: got %0d symbols want %0d", obs_q.size(), exp_q.size());
    end
    for (int unsigned i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL abort_sym%0d: got %s want %s", i, s2s(obs_q[i]), s2s(exp_q[i]));
      end
    end
    vectors++;
    if (obs_q.size() < 2 || obs_q[1].dcterm !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_new_dc: second symbol not the new DC");
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_stall();
    blk_t b;
    gen_block(b, 85);
    run_block(b, 64, 0);
    idle(8);
    for (int unsigned i = 0; i < 64; i++) begin
      if (i == 30) stall(5);
      drive(i == 0, b[i]);
    end
    bus.go = 1'b0;
    model_block(b, 64);
    stall(5);
    idle(8);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL stall_count: got %0d symbols want %0d", obs_q.size(), exp_q.size());
    end
    for (int unsigned i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL stall_sym%0d: got %s want %s", i, s2s(obs_q[i]), s2s(exp_q[i]));
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  // Back-to-back random blocks with aborts, random stalls and DC-state noise.
  task automatic test_random();
    blk_t        b;
    int unsigned n, zp;
    for (int unsigned k = 0; k < 30; k++) begin
      case ($urandom_range(2))
        0:       zp = 60;
        1:       zp = 85;
        default: zp = 97;
      endcase
      gen_block(b, zp);
      n = (k != 29 && $urandom_range(3) == 0) ? $urandom_range(2, 63) : 64;
      run_block(b, n, 10);
      if (n == 64 && $urandom_range(1) == 1) idle_noise($urandom_range(1, 4));
    end
    idle(10);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL random_count: got %0d symbols want %0d", obs_q.size(), exp_q.size());
    end
    for (int unsigned i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL random_sym%0d: got %s want %s", i, s2s(obs_q[i]), s2s(exp_q[i]));
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid();
    blk_t b;
    bit   seen;
    seen = 1'b0;
    gen_block(b, 0);
    for (int unsigned i = 0; i < 64 && !seen; i++) begin
      drive(i == 0, b[i]);
      seen = (bus.den === 1'b1);
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL reset_mid_wait: den never rose within one block");
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({bus.rlen, bus.size, bus.amp, bus.den, bus.dcterm, bus.eob, bus.zrl, ovf} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got %s den=%b ovf=%b, want all 0",
               s2s({bus.rlen, bus.size, bus.amp, bus.dcterm, bus.eob, bus.zrl}), bus.den, ovf);
    end
    bus.go = 1'b0; bus.din = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    obs_q.delete(); exp_q.delete();
    idle_noise(6);
    vectors++;
    if (obs_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid_discard: got %0d stale symbols want 0", obs_q.size());
    end
    obs_q.delete();
    gen_block(b, 85);
    run_block(b, 64, 0);
    idle(8);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL reset_mid_count: got %0d symbols want %0d", obs_q.size(), exp_q.size());
    end
    for (int unsigned i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL reset_mid_sym%0d: got %s want %s", i, s2s(obs_q[i]), s2s(exp_q[i]));
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_abort();
    test_stall();
    test_random();
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_sticky: got %b want 0", ovf);
    end
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
